td4_seq_ctrl: RTL and testbench

- Sequential successor to the TD4 combinational instruction decoder.
- Adds an instruction register, a FETCH/EXEC/HALT state machine and registered carry/zero flags.
- Adds a parametrised immediate width, a fetch handshake, and new JZ, HALT and NOP opcodes.
- Sits between the program ROM and the datapath (A/B registers, adder, output latch, PC). Drives one-cycle, active-high load strobes into the datapath.

---
 rtl/td4_pkg.sv | 49 ++++
 rtl/td4_seq_ctrl_if.sv | 33 +++
 rtl/td4_op_decode.sv | 39 +++
 rtl/td4_seq_ctrl.sv | 85 ++++++++
 tb/tb_td4_seq_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 sequential controller: opcodes, datapath mux
// selects, FSM state codes and the decoded-control bundle.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_NOP_8    = 4'b1000;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_NOP_A    = 4'b1010;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JZ       = 4'b1100;
  localparam logic [3:0] OP_HALT     = 4'b1101;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam logic [1:0] MUX_A    = 2'd0;
  localparam logic [1:0] MUX_B    = 2'd1;
  localparam logic [1:0] MUX_IN   = 2'd2;
  localparam logic [1:0] MUX_ZERO = 2'd3;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef struct packed {
    logic [1:0] mux_sel;
    logic       load_a;
    logic       load_b;
    logic       load_out;
    logic       load_pc;
    logic       inc_pc;
    logic       upd_flags;
    logic       is_halt;
  } dec_t;

  function automatic dec_t dec_idle();
    dec_t d;
    d         = '0;
    d.mux_sel = MUX_A;
    return d;
  endfunction

endpackage

// File: rtl/td4_seq_ctrl_if.sv
// Controller-side bundle between program ROM, controller and datapath.
// The controller connects through 'master'; the ROM/datapath side through 'slave'.
interface td4_seq_ctrl_if #(
  parameter int DATA_W = 4
);
  logic              instr_valid;
  logic [DATA_W+3:0] instr;
  logic              instr_ready;
  logic              alu_carry;
  logic              alu_zero;
  logic [1:0]        mux_sel;
  logic [DATA_W-1:0] imm;
  logic              load_a;
  logic              load_b;
  logic              load_out;
  logic              load_pc;
  logic              inc_pc;
  logic              flag_c;
  logic              flag_z;
  logic              halted;

  modport master (
    input  instr_valid, instr, alu_carry, alu_zero,
    output instr_ready, mux_sel, imm, load_a, load_b, load_out,
           load_pc, inc_pc, flag_c, flag_z, halted
  );

  modport slave (
    output instr_valid, instr, alu_carry, alu_zero,
    input  instr_ready, mux_sel, imm, load_a, load_b, load_out,
           load_pc, inc_pc, flag_c, flag_z, halted
  );
endinterface

// File: rtl/td4_op_decode.sv
// Combinational opcode decoder: opcode plus registered flags to mux select,
// load strobes, PC control, flag-update enable and halt request.
module td4_op_decode
  import td4_pkg::*;
#(
  parameter bit HALT_EN = 1'b1
) (
  input  logic [3:0] opcode_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  output dec_t       dec_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    dec_o = dec_idle();
    unique case (opcode_i)
      OP_ADD_A_IM: begin dec_o.mux_sel = MUX_A;    dec_o.load_a = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_MOV_A_B:  begin dec_o.mux_sel = MUX_B;    dec_o.load_a = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_IN_A:     begin dec_o.mux_sel = MUX_IN;   dec_o.load_a = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_MOV_A_IM: begin dec_o.mux_sel = MUX_ZERO; dec_o.load_a = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_MOV_B_A:  begin dec_o.mux_sel = MUX_A;    dec_o.load_b = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_ADD_B_IM: begin dec_o.mux_sel = MUX_B;    dec_o.load_b = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_IN_B:     begin dec_o.mux_sel = MUX_IN;   dec_o.load_b = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_MOV_B_IM: begin dec_o.mux_sel = MUX_ZERO; dec_o.load_b = 1'b1;   dec_o.upd_flags = 1'b1; end
      OP_OUT_B:    begin dec_o.mux_sel = MUX_B;    dec_o.load_out = 1'b1; dec_o.upd_flags = 1'b1; end
      OP_OUT_IM:   begin dec_o.mux_sel = MUX_ZERO; dec_o.load_out = 1'b1; dec_o.upd_flags = 1'b1; end
      OP_JNC:      begin dec_o.mux_sel = MUX_ZERO; dec_o.load_pc = ~flag_c_i; end
      OP_JZ:       begin dec_o.mux_sel = MUX_ZERO; dec_o.load_pc = flag_z_i;  end
      OP_JMP:      begin dec_o.mux_sel = MUX_ZERO; dec_o.load_pc = 1'b1;      end
      OP_HALT:     dec_o.is_halt = HALT_EN;
      OP_NOP_8, OP_NOP_A: ;
      default: ;
    endcase
    // The PC steps whenever it is not loaded, except when the core stops.
    dec_o.inc_pc = ~dec_o.load_pc & ~dec_o.is_halt;
  end

endmodule

// File: rtl/td4_seq_ctrl.sv
// TD4 sequential controller: instruction register, FETCH/EXEC/HALT FSM and
// registered carry/zero flags; strobes are driven for one cycle in EXEC.
module td4_seq_ctrl
  import td4_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter bit HALT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  td4_seq_ctrl_if.master bus
);

  localparam int INSTR_W = DATA_W + 4;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_z_q, flag_z_d;
  logic               in_exec;
  dec_t               dec;

  td4_op_decode #(
    .HALT_EN (HALT_EN)
  ) u_op_decode (
    .opcode_i (ir_q[INSTR_W-1:DATA_W]),
    .flag_c_i (flag_c_q),
    .flag_z_i (flag_z_q),
    .dec_o    (dec)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    unique case (state_q)
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec.upd_flags) begin
          flag_c_d = bus.alu_carry;
          flag_z_d = bus.alu_zero;
        end
        state_d = dec.is_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign in_exec = (state_q == ST_EXEC);

  assign bus.instr_ready = (state_q == ST_FETCH);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.mux_sel     = in_exec ? dec.mux_sel : MUX_A;
  assign bus.load_a      = in_exec & dec.load_a;
  assign bus.load_b      = in_exec & dec.load_b;
  assign bus.load_out    = in_exec & dec.load_out;
  assign bus.load_pc     = in_exec & dec.load_pc;
  assign bus.inc_pc      = in_exec & dec.inc_pc;
  assign bus.imm         = ir_q[DATA_W-1:0];
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_z      = flag_z_q;

endmodule

// File: tb/tb_td4_seq_ctrl.sv
// Self-checking bench for td4_seq_ctrl: directed scenarios plus random stimulus,
// all checked against a cycle-level behavioural model of the controller.
module tb_td4_seq_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  td4_seq_ctrl_if #(.DATA_W(4)) bus4 ();
  td4_seq_ctrl_if #(.DATA_W(8)) bus8 ();

  td4_seq_ctrl #(.DATA_W(4), .HALT_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  td4_seq_ctrl #(.DATA_W(8), .HALT_EN(1'b0)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = waiting for an instruction, 1 = executing it, 2 = stopped.
  int         m_phase = 0;
  logic [7:0] m_ir    = 8'h00;
  logic       m_fc    = 1'b0;
  logic       m_fz    = 1'b0;

  // Mux source per opcode, straight from the instruction table.
  int mux_tbl [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 0, 3, 3, 0, 3, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] ins,
                       input logic c, input logic z);
    reset            = r;
    bus4.instr_valid = v;
    bus4.instr       = ins;
    bus4.alu_carry   = c;
    bus4.alu_zero    = z;
  endtask

  task automatic model_step();
    int op;
    op = int'(m_ir[7:4]);
    if (reset) begin
      m_phase = 0;
      m_ir    = 8'h00;
      m_fc    = 1'b0;
      m_fz    = 1'b0;
    end else if (m_phase == 0) begin
      if (bus4.instr_valid) begin
        m_ir    = bus4.instr;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (op <= 7 || op == 9 || op == 11) begin
        m_fc = bus4.alu_carry;
        m_fz = bus4.alu_zero;
      end
      m_phase = (op == 13) ? 2 : 0;
    end
  endtask

  task automatic check_outputs();
    int   op;
    logic ex, taken;
    logic [4:0] exp_strb;
    op    = int'(m_ir[7:4]);
    ex    = (m_phase == 1);
    taken = (op == 15) || (op == 14 && !m_fc) || (op == 12 && m_fz);
    exp_strb = {ex && op < 4, ex && op >= 4 && op < 8, ex && (op == 9 || op == 11),
                ex && taken, ex && !taken && op != 13};
    check("strobes", {bus4.load_a, bus4.load_b, bus4.load_out, bus4.load_pc, bus4.inc_pc}, exp_strb);
    check("mux_sel", bus4.mux_sel, ex ? mux_tbl[op] : 0);
    check("imm",     bus4.imm, m_ir[3:0]);
    check("flags",   {bus4.flag_c, bus4.flag_z}, {m_fc, m_fz});
    check("ready",   bus4.instr_ready, m_phase == 0);
    check("halted",  bus4.halted, m_phase == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_outputs();
  endtask

  // Present an instruction in FETCH; returns with the DUT in EXEC.
  task automatic issue(input logic [7:0] ins, input logic c, input logic z);
    drive(1'b0, 1'b1, ins, c, z);
    tick();
  endtask

  initial begin
    int halt_cycles;
    bus8.instr_valid = 1'b0;
    bus8.instr       = '0;
    bus8.alu_carry   = 1'b0;
    bus8.alu_zero    = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_ready", bus4.instr_ready, 1);

    // MOV A,Im 5
    issue(8'h35, 1'b0, 1'b0);
    check("mov_a_load_a", bus4.load_a, 1);
    check("mov_a_mux", bus4.mux_sel, 3);
    check("mov_a_imm", bus4.imm, 5);
    check("mov_a_inc", bus4.inc_pc, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("mov_a_ready_after", bus4.instr_ready, 1);

    // ADD A,Im with carry and zero, then JNC must fall through
    issue(8'h01, 1'b1, 1'b1);
    tick();
    issue(8'hEA, 1'b0, 1'b0);
    check("jnc_flags", {bus4.flag_c, bus4.flag_z}, 2'b11);
    check("jnc_nc_load_pc", bus4.load_pc, 0);
    check("jnc_nc_inc", bus4.inc_pc, 1);
    tick();
    issue(8'h01, 1'b0, 1'b1);
    tick();
    issue(8'hEA, 1'b1, 1'b0);
    check("jnc_taken_load_pc", bus4.load_pc, 1);
    check("jnc_taken_imm", bus4.imm, 4'hA);
    check("jnc_taken_inc", bus4.inc_pc, 0);
    tick();

    // MOV B,Im sets Z, JZ taken, JMP holds flags, JZ taken again
    issue(8'h73, 1'b0, 1'b1);
    tick();
    issue(8'hC3, 1'b1, 1'b0);
    check("jz_load_pc", bus4.load_pc, 1);
    tick();
    issue(8'hF0, 1'b1, 1'b0);
    tick();
    issue(8'hC3, 1'b1, 1'b0);
    check("jz_after_jmp_load_pc", bus4.load_pc, 1);
    check("jz_after_jmp_flags", {bus4.flag_c, bus4.flag_z}, 2'b01);
    tick();

    // Stall in FETCH for 5 cycles
    drive(1'b0, 1'b0, 8'h12, 1'b1, 1'b0);
    repeat (5) tick();
    check("stall_imm", bus4.imm, 3);
    check("stall_flags", {bus4.flag_c, bus4.flag_z}, 2'b01);
    issue(8'h12, 1'b1, 1'b0);
    check("resume_load_a", bus4.load_a, 1);
    check("resume_mux", bus4.mux_sel, 1);
    tick();

    // HALT: stuck until reset
    issue(8'hD0, 1'b0, 1'b0);
    check("halt_inc", bus4.inc_pc, 0);
    tick();
    check("halted", bus4.halted, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    check("halted_strobes", {bus4.load_a, bus4.load_b, bus4.load_out, bus4.load_pc,
                             bus4.inc_pc, bus4.instr_ready}, 0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("halt_reset", {bus4.halted, bus4.instr_ready, bus4.flag_c, bus4.flag_z}, 4'b0100);

    // Reset during EXEC suppresses the flag update
    issue(8'h01, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    check("rst_exec_flags", {bus4.flag_c, bus4.flag_z}, 2'b00);
    check("rst_exec_load_a", bus4.load_a, 0);

    // Wide instance, with HALT decoding as NOP
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    bus8.instr_valid = 1'b1;
    bus8.instr       = 12'h3F7;
    tick();
    check("w8_imm", bus8.imm, 8'hF7);
    check("w8_load_a", bus8.load_a, 1);
    check("w8_mux", bus8.mux_sel, 3);
    bus8.instr = 12'hD00;
    tick();
    tick();
    check("w8_halt_nop_inc", bus8.inc_pc, 1);
    check("w8_halt_nop_halted", bus8.halted, 0);
    bus8.instr_valid = 1'b0;
    tick();
    check("w8_halt_nop_ready", bus8.instr_ready, 1);

    // Random traffic against the model
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      halt_cycles = (m_phase == 2) ? halt_cycles + 1 : 0;
      drive(($urandom_range(0, 99) < 2) || (halt_cycles > 12),
            $urandom_range(0, 99) < 70, 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
